// File: rtl/mem_bit_loader.sv
// Serial bit-stream loader: packs bits LSB-first into words and writes them to sequential memory addresses.
// Optional running-parity output is enabled by defining MEM_BIT_LOADER_PARITY_EN.
module mem_bit_loader #(
  parameter int C_WORDSIZE = 8,
  parameter int C_ADDRSIZE = 10
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_start,
  input  logic [C_ADDRSIZE:0]   I_nwords,
  input  logic                  I_bit,
  input  logic                  I_bvalid,
  output logic                  O_bready,
  output logic                  O_wen,
  output logic [C_ADDRSIZE-1:0] O_addr,
  output logic [C_WORDSIZE-1:0] O_wdata,
  output logic                  O_busy,
  output logic                  O_done
`ifdef MEM_BIT_LOADER_PARITY_EN
  ,
  output logic                  O_parity
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int                  BIDX_W     = (C_WORDSIZE > 1) ? $clog2(C_WORDSIZE) : 1;
  localparam logic [BIDX_W-1:0]   LAST_BIT_C = BIDX_W'(C_WORDSIZE - 1);
  localparam logic [BIDX_W-1:0]   BIDX_ONE_C = BIDX_W'(1);
  localparam logic [BIDX_W-1:0]   BIDX_ZERO_C = BIDX_W'(0);
  localparam logic [C_ADDRSIZE:0] DEPTH_C    = {1'b1, {C_ADDRSIZE{1'b0}}};
  localparam logic [C_ADDRSIZE:0] CNT_ONE_C  = {{C_ADDRSIZE{1'b0}}, 1'b1};
  localparam logic [C_ADDRSIZE:0] CNT_ZERO_C = {(C_ADDRSIZE + 1){1'b0}};

  function automatic logic parity_next(input logic par, input logic bit_in);
    parity_next = par ^ bit_in;
  endfunction

  logic [1:0]            state_r;
  logic [1:0]            next_state_s;
  logic [C_ADDRSIZE:0]   nwords_r;
  logic [C_ADDRSIZE:0]   nwords_in_s;
  logic [C_ADDRSIZE:0]   wcnt_r;
  logic [C_ADDRSIZE:0]   wcnt_inc_s;
  logic [BIDX_W-1:0]     bit_idx_r;
  logic [C_WORDSIZE-1:0] shreg_r;
  logic [C_WORDSIZE-1:0] word_s;
  logic                  accept_s;
  logic                  start_ok_s;
  logic                  bready_r;
  logic                  wen_r;
  logic                  busy_r;
  logic                  done_r;
  logic [C_ADDRSIZE-1:0] addr_r;
  logic [C_WORDSIZE-1:0] wdata_r;
`ifdef MEM_BIT_LOADER_PARITY_EN
  logic                  parity_r;
`endif

  // Handshake decode, word packing view and next-state selection.
  always_comb begin
    accept_s   = (state_r == S_FILL) && I_bvalid;
    start_ok_s = (state_r == S_IDLE) && I_start;
    wcnt_inc_s = wcnt_r + CNT_ONE_C;
    if (I_nwords > DEPTH_C) begin
      nwords_in_s = DEPTH_C;
    end else begin
      nwords_in_s = I_nwords;
    end
    word_s            = shreg_r;
    word_s[bit_idx_r] = I_bit;
    next_state_s      = state_r;
    case (state_r)
      S_IDLE: begin
        if (!I_start) begin
          next_state_s = S_IDLE;
        end else if (nwords_in_s == CNT_ZERO_C) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_FILL;
        end
      end
      S_FILL: begin
        if (accept_s && (bit_idx_r == LAST_BIT_C)) begin
          next_state_s = S_WRITE;
        end else begin
          next_state_s = S_FILL;
        end
      end
      S_WRITE: begin
        if (wcnt_inc_s == nwords_r) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_FILL;
        end
      end
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // State, datapath and output registers; outputs are decoded from the next state so they are registered.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_r   <= S_IDLE;
      nwords_r  <= CNT_ZERO_C;
      wcnt_r    <= CNT_ZERO_C;
      bit_idx_r <= BIDX_ZERO_C;
      shreg_r   <= {C_WORDSIZE{1'b0}};
      bready_r  <= 1'b0;
      wen_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      addr_r    <= {C_ADDRSIZE{1'b0}};
      wdata_r   <= {C_WORDSIZE{1'b0}};
`ifdef MEM_BIT_LOADER_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      state_r  <= next_state_s;
      bready_r <= (next_state_s == S_FILL);
      wen_r    <= (next_state_s == S_WRITE);
      busy_r   <= (next_state_s != S_IDLE);
      done_r   <= (next_state_s == S_DONE);
      if (start_ok_s) begin
        nwords_r  <= nwords_in_s;
        wcnt_r    <= CNT_ZERO_C;
        bit_idx_r <= BIDX_ZERO_C;
        shreg_r   <= {C_WORDSIZE{1'b0}};
      end else if (accept_s) begin
        shreg_r   <= word_s;
        bit_idx_r <= (bit_idx_r == LAST_BIT_C) ? BIDX_ZERO_C : (bit_idx_r + BIDX_ONE_C);
      end else if (state_r == S_WRITE) begin
        wcnt_r <= wcnt_inc_s;
      end
      // Address/data are captured only when a write is about to issue and held otherwise.
      if (next_state_s == S_WRITE) begin
        addr_r  <= wcnt_r[C_ADDRSIZE-1:0];
        wdata_r <= word_s;
      end
`ifdef MEM_BIT_LOADER_PARITY_EN
      if (start_ok_s) begin
        parity_r <= 1'b0;
      end else if (accept_s) begin
        parity_r <= parity_next(parity_r, I_bit);
      end
`endif
    end
  end

  assign O_bready = bready_r;
  assign O_wen    = wen_r;
  assign O_addr   = addr_r;
  assign O_wdata  = wdata_r;
  assign O_busy   = busy_r;
  assign O_done   = done_r;
`ifdef MEM_BIT_LOADER_PARITY_EN
  assign O_parity = parity_r;
`endif

endmodule

// File: tb/tb_mem_bit_loader.sv
// Self-checking bench for mem_bit_loader (C_WORDSIZE=8, C_ADDRSIZE=4) against a word-list reference model.
module tb_mem_bit_loader;
  localparam int WS = 8;
  localparam int AS = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          I_rst = 1'b0;
  logic          I_start = 1'b0;
  logic [AS:0]   I_nwords = '0;
  logic          I_bit = 1'b0;
  logic          I_bvalid = 1'b0;
  logic          O_bready, O_wen, O_busy, O_done;
  logic [AS-1:0] O_addr;
  logic [WS-1:0] O_wdata;
`ifdef MEM_BIT_LOADER_PARITY_EN
  logic          O_parity;
`endif

  mem_bit_loader #(.C_WORDSIZE(WS), .C_ADDRSIZE(AS)) dut (
    .I_clk(clk), .I_rst(I_rst), .I_start(I_start), .I_nwords(I_nwords),
    .I_bit(I_bit), .I_bvalid(I_bvalid), .O_bready(O_bready), .O_wen(O_wen),
    .O_addr(O_addr), .O_wdata(O_wdata), .O_busy(O_busy), .O_done(O_done)
`ifdef MEM_BIT_LOADER_PARITY_EN
    , .O_parity(O_parity)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [WS-1:0] words_a [0:31];
  logic [AS-1:0] wq_addr [$];
  logic [WS-1:0] wq_data [$];
  int done_cnt = 0, conflict_cnt = 0, cyc = 0, last_wen_cyc = 0, done_cyc = 0;

  // Observe the write port and completion pulses a little after each rising edge.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (O_wen) begin
      wq_addr.push_back(O_addr);
      wq_data.push_back(O_wdata);
      last_wen_cyc = cyc;
      if (O_bready) conflict_cnt++;
    end
    if (O_done) begin
      done_cnt++;
      done_cyc = cyc;
      if (O_bready) conflict_cnt++;
    end
  end

  task automatic clear_obs();
    wq_addr.delete();
    wq_data.delete();
    done_cnt = 0;
    conflict_cnt = 0;
  endtask

  // mode: 0 = valid held, 1 = valid every other cycle, 2 = random valid; restart_at injects a start mid-load.
  task automatic run_load(input int n, input int mode, input int restart_at, input string name);
    int eff, idx, cyc_i, ones;
    logic [WS-1:0] tmp;
    eff = (n > DEPTH) ? DEPTH : n;
    clear_obs();
    @(negedge clk);
    I_start = 1'b1;
    I_nwords = n[AS:0];
    @(negedge clk);
    I_start = 1'b0;
    if (eff > 0) begin
      n_cmp++;
      if ({O_busy, O_bready} !== 2'b11) begin
        n_err++;
        $display("FAIL %s busy_bready_after_start: got %b required 11", name, {O_busy, O_bready});
      end
    end else begin
      n_cmp++;
      if ({O_done, O_busy} !== 2'b11) begin
        n_err++;
        $display("FAIL %s done_after_start: got %b required 11", name, {O_done, O_busy});
      end
    end
    idx = 0;
    cyc_i = 0;
    while (done_cnt == 0 && cyc_i < 2000) begin
      case (mode)
        0:       I_bvalid = 1'b1;
        1:       I_bvalid = ((cyc_i % 2) == 0);
        default: I_bvalid = 1'($urandom_range(0, 1));
      endcase
      tmp = words_a[(idx / WS) % 32];
      I_bit = tmp[idx % WS];
      I_start = (cyc_i == restart_at);
      if (cyc_i == restart_at) I_nwords = 5'd1;
      if (I_bvalid && O_bready) idx++;
      @(negedge clk);
      cyc_i++;
    end
    I_start = 1'b0;
    I_bvalid = 1'b0;
    n_cmp++;
    if (done_cnt == 0) begin
      n_err++;
      $display("FAIL %s timeout: got no done required done within 2000 cycles", name);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt !== 1) begin
      n_err++;
      $display("FAIL %s done_count: got %0d required 1", name, done_cnt);
    end
    n_cmp++;
    if (wq_addr.size() !== eff) begin
      n_err++;
      $display("FAIL %s write_count: got %0d required %0d", name, wq_addr.size(), eff);
    end
    for (int i = 0; i < eff && i < wq_addr.size(); i++) begin
      n_cmp++;
      if (wq_addr[i] !== AS'(i) || wq_data[i] !== words_a[i]) begin
        n_err++;
        $display("FAIL %s write%0d: got addr %0d data %02h required addr %0d data %02h",
                 name, i, wq_addr[i], wq_data[i], i, words_a[i]);
      end
    end
    if (eff > 0) begin
      n_cmp++;
      if (done_cyc !== last_wen_cyc + 1) begin
        n_err++;
        $display("FAIL %s done_timing: got cycle %0d required %0d", name, done_cyc, last_wen_cyc + 1);
      end
    end
    n_cmp++;
    if (conflict_cnt !== 0 || idx !== eff * WS) begin
      n_err++;
      $display("FAIL %s bits_consumed: got %0d (ready conflicts %0d) required %0d (0)",
               name, idx, conflict_cnt, eff * WS);
    end
    n_cmp++;
    if (O_busy !== 1'b0 || O_bready !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle_after_done: got busy %b ready %b required 0 0", name, O_busy, O_bready);
    end
`ifdef MEM_BIT_LOADER_PARITY_EN
    ones = 0;
    for (int i = 0; i < eff; i++) ones += $countones(words_a[i]);
    n_cmp++;
    if (O_parity !== 1'((ones % 2))) begin
      n_err++;
      $display("FAIL %s parity: got %b required %0d", name, O_parity, ones % 2);
    end
`else
    ones = 0;
`endif
  endtask

  task automatic randomize_words();
    for (int i = 0; i < 32; i++) words_a[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    I_rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({O_bready, O_wen, O_busy, O_done} !== 4'b0000 || O_addr !== 4'd0 || O_wdata !== 8'd0) begin
      n_err++;
      $display("FAIL reset_values: got ready%b wen%b busy%b done%b addr%0d data%02h required all 0",
               O_bready, O_wen, O_busy, O_done, O_addr, O_wdata);
    end
    I_rst = 1'b0;
  endtask

  task automatic test_basic();
    randomize_words();
    words_a[0] = 8'hA5;
    words_a[1] = 8'h3C;
    run_load(2, 0, -1, "basic_held");
  endtask

  task automatic test_toggle_valid();
    randomize_words();
    words_a[0] = 8'hA5;
    words_a[1] = 8'h3C;
    run_load(2, 1, -1, "toggle_valid");
  endtask

  task automatic test_bounds();
    randomize_words();
    run_load(0, 0, -1, "zero_words");
    run_load(20, 0, -1, "overflow_words");
    run_load(16, 2, -1, "full_depth");
  endtask

  task automatic test_start_mid_fill();
    randomize_words();
    run_load(3, 0, 4, "start_mid_fill");
  endtask

  task automatic test_reset_mid_fill();
    logic [WS-1:0] tmp;
    randomize_words();
    clear_obs();
    @(negedge clk);
    I_start = 1'b1;
    I_nwords = 5'd2;
    @(negedge clk);
    I_start = 1'b0;
    tmp = words_a[0];
    for (int k = 0; k < 5; k++) begin
      I_bvalid = 1'b1;
      I_bit = tmp[k];
      @(negedge clk);
    end
    I_rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({O_bready, O_wen, O_busy, O_done} !== 4'b0000 || O_addr !== 4'd0 || O_wdata !== 8'd0
        || wq_addr.size() !== 0) begin
      n_err++;
      $display("FAIL reset_mid_fill: got ready%b wen%b busy%b done%b addr%0d data%02h writes%0d required all 0",
               O_bready, O_wen, O_busy, O_done, O_addr, O_wdata, wq_addr.size());
    end
    I_rst = 1'b0;
    I_bvalid = 1'b0;
    words_a[0] = 8'h5A;
    run_load(1, 0, -1, "fresh_after_reset");
  endtask

  task automatic test_parity();
    randomize_words();
    words_a[0] = 8'h01;
    run_load(1, 0, -1, "parity_single");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      randomize_words();
      run_load($urandom_range(0, 20), 2, -1, "random_load");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle_valid();
    test_bounds();
    test_start_mid_fill();
    test_reset_mid_fill();
    test_parity();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bit_loader.md
# mem_bit_loader

Upstream fill stage for the synchronous word memory. Accepts a serial PUF response bit stream over a valid/ready handshake, packs bits LSB-first into C_WORDSIZE-bit words, and writes each completed word into the memory at sequentially incrementing addresses from 0. A load runs for a programmed word count, then signals completion so the downstream encoder can start reading.

## Interface
- C_WORDSIZE, 8, word width; must match the memory word width
- C_ADDRSIZE, 10, memory address width; memory depth is 2^C_ADDRSIZE words

- I_clk  in  1  clock, all logic on rising edge
- I_rst  in  1  reset, synchronous, active-high
- I_start  in  1  one-cycle start pulse; honoured only in IDLE
- I_nwords  in  C_ADDRSIZE+1  words to load, sampled on accepted I_start
- I_bit  in  1  serial data bit
- I_bvalid  in  1  I_bit valid
- O_bready  out  1  loader can accept a bit this cycle
- O_wen  out  1  memory write enable, one-cycle pulse per word
- O_addr  out  C_ADDRSIZE  memory address
- O_wdata  out  C_WORDSIZE  memory write data
- O_busy  out  1  high from accepted start until DONE exits
- O_done  out  1  one-cycle completion pulse
- O_parity  out  1  running even parity of loaded bits (only with MEM_BIT_LOADER_PARITY_EN)

## Operation
- States: IDLE, FILL, WRITE, DONE.
- IDLE: O_bready=0, O_busy=0. On I_start: latch nwords = min(I_nwords, 2^C_ADDRSIZE), clear word count, bit index, shift register, parity. If latched nwords==0 go to DONE, else FILL.
- FILL: O_bready=1, O_busy=1. Bit accepted when I_bvalid && O_bready; stored at bit position = bit index (first bit -> bit 0). Bit index increments per accepted bit; when bit C_WORDSIZE-1 is accepted, go to WRITE, bit index wraps to 0.
- WRITE: exactly one cycle. O_wen=1, O_addr=word count[C_ADDRSIZE-1:0], O_wdata=packed word, O_bready=0. Word count increments. If new count == nwords go to DONE, else FILL.
- DONE: one cycle, O_done=1, O_busy=1, O_bready=0; then IDLE.
- I_start outside IDLE ignored. I_bvalid outside FILL ignored (no bit consumed).
- O_addr/O_wdata are held at their last values when O_wen=0; only meaningful while O_wen=1.
- Reset (any state): next edge -> IDLE; partial word discarded, no O_wen issued.

## Timing
- Reset values: O_bready=0, O_wen=0, O_addr=0, O_wdata=0, O_busy=0, O_done=0, O_parity=0.
- O_busy and O_bready rise the cycle after the accepted I_start (nwords>0).
- Last bit of a word accepted on edge N -> O_wen high during cycle N+1 -> write lands on edge N+2's preceding edge (memory samples at end of that cycle).
- Throughput: C_WORDSIZE+1 cycles per word with I_bvalid held high.
- Last write cycle followed immediately by DONE cycle; O_done occurs exactly once per load.
- I_rst has priority over I_start in the same cycle.

## Configuration
- MEM_BIT_LOADER_PARITY_EN defined: O_parity present; cleared on accepted start and reset, XORed with every accepted bit; stable from DONE until next accepted start.
- Not defined: O_parity port and parity register absent; all other behaviour identical.

## Test plan
- C_WORDSIZE=8, C_ADDRSIZE=4, I_nwords=2, bits for 0xA5 then 0x3C LSB-first, I_bvalid held -> O_wen at addr 0 data 0xA5, addr 1 data 0x3C, O_done one cycle after second write; O_parity=0 (8 ones).
- Same load, I_bvalid toggling every other cycle -> identical writes, no bit lost or duplicated, O_bready low during WRITE.
- I_nwords=0 -> O_done one cycle after start, no O_wen; I_nwords=20 -> exactly 16 writes, addr 0..15, then O_done.
- I_start pulsed mid-FILL -> ignored, load completes unchanged.
- I_rst asserted after 5 bits of word 0 -> next cycle all outputs at reset values, no write; new start loads fresh word at addr 0.
- Parity build: bits 1,0,0,0,0,0,0,0 with I_nwords=1 -> write 0x01 at addr 0, O_parity=1.
